// File: rtl/shift_rotate_seq_if.sv
// Request/result handshake bundle for the multi-cycle shift/rotate unit.
// Request side:  in_valid/in_ready handshake carrying in_data, in_cnt, in_op.
// Result side:   out_valid/out_ready handshake carrying out_data.
// master: the requester/consumer (ALU-side sequencer or bench).
// slave:  the shift/rotate unit itself.
interface shift_rotate_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_rotate_seq.sv
// Multi-cycle shift/rotate unit for the execute datapath.
// One log-barrel stage (weight 2**stage) is applied per cycle; the operation
// finishes as soon as no higher count bits remain.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_rotate_seq_if.slave: request and result handshakes
//   busy   high whenever the unit is not idle
// in_op: 00 ROL, 01 SLL, 10 ROR, 11 SRL
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | applying one weighted stage per cycle to acc
// DONE  | result presented on out_data, held until out_ready
module shift_rotate_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_rotate_seq_if.slave   bus,
    output logic                busy
);
    localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateT;

    stateT              state;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op;
    logic [STG_W-1:0]   stage;
    logic               outValidReg;
    logic [WIDTH-1:0]   outDataReg;
    logic               inReadyReg;
    logic               busyReg;

    logic [CNT_W-1:0]   stepAmt;
    logic [2*WIDTH-1:0] rolFull;
    logic [2*WIDTH-1:0] rorFull;
    logic [WIDTH-1:0]   moved;
    logic [WIDTH-1:0]   stepVal;
    logic               moreBits;
    logic               lastStage;

    // Rotates use a doubled copy of acc so the wrapped bits fall out of the
    // opposite half of the shifted word.
    always_comb begin
        stepAmt        = '0;
        stepAmt[stage] = 1'b1;
        rolFull        = {acc, acc} << stepAmt;
        rorFull        = {acc, acc} >> stepAmt;
        case (op)
            2'b00:   moved = rolFull[2*WIDTH-1:WIDTH];
            2'b01:   moved = acc << stepAmt;
            2'b10:   moved = rorFull[WIDTH-1:0];
            default: moved = acc >> stepAmt;
        endcase
        stepVal = cnt[stage] ? moved : acc;

        moreBits = 1'b0;
        for (int i = 0; i < CNT_W; i++) begin
            if ((i > int'(stage)) && cnt[i]) begin
                moreBits = 1'b1;
            end
        end
        lastStage = (int'(stage) == CNT_W - 1) || !moreBits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            op          <= '0;
            stage       <= '0;
            outValidReg <= 1'b0;
            outDataReg  <= '0;
            inReadyReg  <= 1'b1;
            busyReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc        <= bus.in_data;
                        cnt        <= bus.in_cnt;
                        op         <= bus.in_op;
                        stage      <= '0;
                        state      <= SHIFT;
                        inReadyReg <= 1'b0;
                        busyReg    <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc <= stepVal;
                    if (lastStage) begin
                        // out_data is loaded only here, so it never shows partial results.
                        outDataReg  <= stepVal;
                        outValidReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValidReg <= 1'b0;
                        inReadyReg  <= 1'b1;
                        busyReg     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                    busyReg     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReadyReg;
    assign bus.out_valid = outValidReg;
    assign bus.out_data  = outDataReg;
    assign busy          = busyReg;
endmodule

// File: tb/tb_shift_rotate_seq.sv
module tb_shift_rotate_seq;
    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   failures;

    shift_rotate_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_rotate_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  cnt;
        logic [1:0]  op;
        logic [15:0] expData;
        int          expLat;
    } vecT;

    vecT vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: apply the operation one bit position at a time, cnt times.
    function automatic logic [15:0] refModel(input logic [15:0] d, input int n, input logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    function automatic int refLat(input int n);
        int l;
        l = 0;
        for (int i = 0; i < 4; i++) begin
            if (((n >> i) & 1) == 1) l = i + 1;
        end
        return (l == 0) ? 1 : l;
    endfunction

    // Issue one request from a #1-after-edge point; returns latency and result,
    // leaving the unit in DONE with out_ready low.
    task automatic doReq(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                         output int lat, output logic [15:0] res);
        check("in_ready_before_req", {31'd0, bus.in_ready}, 32'd1);
        bus.in_data  = d;
        bus.in_cnt   = c;
        bus.in_op    = o;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL timeout_out_valid: got 0 expected 1");
        end
        res = bus.out_data;
    endtask

    task automatic popResult();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("pop_out_valid_low", {31'd0, bus.out_valid}, 32'd0);
        check("pop_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
        check("pop_busy_low", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic [15:0] res;
        logic [15:0] held;
        logic [15:0] rd;
        logic [3:0]  rc;
        logic [1:0]  ro;
        logic [15:0] qd[3];
        logic [3:0]  qc[3];
        logic [1:0]  qo[3];
        logic [15:0] got[$];
        int          idx;
        int          cyc;
        logic        accNow;
        logic        popNow;
        logic [15:0] popData;
        logic        sawValid;

        checks   = 0;
        failures = 0;

        vecs[0] = '{16'h8001, 4'd1,  2'b00, 16'h0003, 1};
        vecs[1] = '{16'h1234, 4'd15, 2'b00, 16'h091A, 4};
        vecs[2] = '{16'h0001, 4'd1,  2'b10, 16'h8000, 1};
        vecs[3] = '{16'hFFFF, 4'd4,  2'b01, 16'hFFF0, 3};
        vecs[4] = '{16'h8000, 4'd15, 2'b11, 16'h0001, 4};
        vecs[5] = '{16'hABCD, 4'd0,  2'b00, 16'hABCD, 1};
        vecs[6] = '{16'h5A5A, 4'd0,  2'b11, 16'h5A5A, 1};
        vecs[7] = '{16'h0001, 4'd15, 2'b01, 16'h8000, 4};
        vecs[8] = '{16'h1234, 4'd8,  2'b10, 16'h3412, 4};
        vecs[9] = '{16'hF000, 4'd2,  2'b11, 16'h3C00, 2};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cnt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, bus.out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) begin
            doReq(vecs[i].data, vecs[i].cnt, vecs[i].op, lat, res);
            check($sformatf("vec%0d_data", i), {16'd0, res}, {16'd0, vecs[i].expData});
            check($sformatf("vec%0d_lat", i), lat, vecs[i].expLat);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
            popResult();
        end

        for (int i = 0; i < 40; i++) begin
            rd = 16'($urandom);
            rc = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            doReq(rd, rc, ro, lat, res);
            check($sformatf("rand%0d_data", i), {16'd0, res}, {16'd0, refModel(rd, int'(rc), ro)});
            check($sformatf("rand%0d_lat", i), lat, refLat(int'(rc)));
            popResult();
        end

        // Backpressure in DONE, with a dropped in_valid pulse.
        doReq(16'h00F0, 4'd3, 2'b10, lat, res);
        held = res;
        check("bp_result", {16'd0, res}, 32'h0000001E);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.in_data  = 16'hDEAD;
                bus.in_cnt   = 4'd5;
                bus.in_op    = 2'b01;
                bus.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_out_data", {16'd0, bus.out_data}, {16'd0, held});
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        popResult();
        repeat (3) @(posedge clk);
        #1;
        check("bp_drop_no_busy", {31'd0, busy}, 32'd0);
        check("bp_drop_no_valid", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back: in_valid held with three queued requests, consumer always ready.
        qd[0] = 16'h1234; qc[0] = 4'd4;  qo[0] = 2'b00;
        qd[1] = 16'h8421; qc[1] = 4'd9;  qo[1] = 2'b11;
        qd[2] = 16'h0F0F; qc[2] = 4'd0;  qo[2] = 2'b01;
        idx = 0;
        cyc = 0;
        bus.out_ready = 1'b1;
        while ((got.size() < 3) && (cyc < 60)) begin
            if (idx < 3) begin
                bus.in_data  = qd[idx];
                bus.in_cnt   = qc[idx];
                bus.in_op    = qo[idx];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            accNow  = bus.in_valid && bus.in_ready;
            popNow  = bus.out_valid && bus.out_ready;
            popData = bus.out_data;
            @(posedge clk); #1;
            cyc++;
            if (accNow) idx++;
            if (popNow) got.push_back(popData);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepts", idx, 3);
        check("b2b_results", got.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                check($sformatf("b2b_res%0d", i), {16'd0, got[i]},
                      {16'd0, refModel(qd[i], int'(qc[i]), qo[i])});
            end
        end
        @(posedge clk); #1;

        // Reset in the second SHIFT cycle of ROL cnt=8.
        bus.in_data  = 16'h1357;
        bus.in_cnt   = 4'd8;
        bus.in_op    = 2'b00;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_out_data", {16'd0, bus.out_data}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) sawValid = 1'b1;
        end
        check("mid_rst_no_pulse", {31'd0, sawValid}, 32'd0);
        doReq(16'h1357, 4'd8, 2'b00, lat, res);
        check("post_rst_data", {16'd0, res}, 32'h00005713);
        check("post_rst_lat", lat, 4);
        popResult();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
